// File: rtl/mul_div_rs.sv
// mul_div_rs: reservation station feeding the Mul_Div unit with CDB wakeup.
// Optional dispatch-time CDB bypass is enabled by defining MUL_DIV_RS_BYPASS_EN.
`default_nettype none

module mul_div_rs #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [4:0]       disp_execute_type,
   input  logic [TAG_W-1:0] disp_dest_tag,
   input  logic [TAG_W-1:0] disp_src1_tag,
   input  logic [TAG_W-1:0] disp_src2_tag,
   input  logic             disp_src1_rdy,
   input  logic             disp_src2_rdy,
   input  logic [31:0]      disp_src1_val,
   input  logic [31:0]      disp_src2_val,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             issue_valid,
   input  logic             issue_ready,
   output logic [31:0]      operand1,
   output logic [31:0]      operand2,
   output logic [4:0]       execute_type,
   output logic [TAG_W-1:0] issue_dest_tag
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_s1_rdy;
   logic [DEPTH-1:0] r_s2_rdy;
   logic [4:0]       r_type   [DEPTH];
   logic [TAG_W-1:0] r_dest   [DEPTH];
   logic [TAG_W-1:0] r_s1_tag [DEPTH];
   logic [TAG_W-1:0] r_s2_tag [DEPTH];
   logic [31:0]      r_s1_val [DEPTH];
   logic [31:0]      r_s2_val [DEPTH];

   logic [DEPTH-1:0] w_elig;
   logic [IDX_W-1:0] w_free_idx;
   logic [IDX_W-1:0] w_iss_idx;
   logic             w_disp_fire;
   logic             w_issue_fire;
   logic             w_d1_byp;
   logic             w_d2_byp;

   assign w_elig       = r_valid & r_s1_rdy & r_s2_rdy;
   assign disp_ready   = ~&r_valid;
   assign issue_valid  = |w_elig;
   assign w_disp_fire  = disp_valid && disp_ready;
   assign w_issue_fire = issue_valid && issue_ready;

   // Scanning from the top down leaves the lowest matching index selected.
   always_comb begin
      w_free_idx = '0;
      w_iss_idx  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = IDX_W'(i);
         if (w_elig[i])   w_iss_idx  = IDX_W'(i);
      end
   end

   always_comb begin
      operand1       = '0;
      operand2       = '0;
      execute_type   = '0;
      issue_dest_tag = '0;
      if (issue_valid) begin
         operand1       = r_s1_val[w_iss_idx];
         operand2       = r_s2_val[w_iss_idx];
         execute_type   = r_type[w_iss_idx];
         issue_dest_tag = r_dest[w_iss_idx];
      end
   end

`ifdef MUL_DIV_RS_BYPASS_EN
   assign w_d1_byp = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
   assign w_d2_byp = cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag);
`else
   assign w_d1_byp = 1'b0;
   assign w_d2_byp = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= '0;
         r_s1_rdy <= '0;
         r_s2_rdy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_type[i]   <= '0;
            r_dest[i]   <= '0;
            r_s1_tag[i] <= '0;
            r_s2_tag[i] <= '0;
            r_s1_val[i] <= '0;
            r_s2_val[i] <= '0;
         end
      end else if (flush) begin
         r_valid  <= '0;
         r_s1_rdy <= '0;
         r_s2_rdy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && cdb_valid) begin
               if (!r_s1_rdy[i] && (r_s1_tag[i] == cdb_tag)) begin
                  r_s1_rdy[i] <= 1'b1;
                  r_s1_val[i] <= cdb_data;
               end
               if (!r_s2_rdy[i] && (r_s2_tag[i] == cdb_tag)) begin
                  r_s2_rdy[i] <= 1'b1;
                  r_s2_val[i] <= cdb_data;
               end
            end
         end
         // Issue frees a valid entry, dispatch fills an invalid one: never the same slot.
         if (w_issue_fire) r_valid[w_iss_idx] <= 1'b0;
         if (w_disp_fire) begin
            r_valid[w_free_idx]  <= 1'b1;
            r_type[w_free_idx]   <= disp_execute_type;
            r_dest[w_free_idx]   <= disp_dest_tag;
            r_s1_tag[w_free_idx] <= disp_src1_tag;
            r_s2_tag[w_free_idx] <= disp_src2_tag;
            r_s1_rdy[w_free_idx] <= disp_src1_rdy || w_d1_byp;
            r_s2_rdy[w_free_idx] <= disp_src2_rdy || w_d2_byp;
            r_s1_val[w_free_idx] <= w_d1_byp ? cdb_data : disp_src1_val;
            r_s2_val[w_free_idx] <= w_d2_byp ? cdb_data : disp_src2_val;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_rs.sv
// tb_mul_div_rs: directed self-checking bench for mul_div_rs.
`default_nettype none

module tb_mul_div_rs;

   localparam int DEPTH = 4;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic [4:0]       disp_execute_type;
   logic [TAG_W-1:0] disp_dest_tag;
   logic [TAG_W-1:0] disp_src1_tag;
   logic [TAG_W-1:0] disp_src2_tag;
   logic             disp_src1_rdy;
   logic             disp_src2_rdy;
   logic [31:0]      disp_src1_val;
   logic [31:0]      disp_src2_val;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;
   logic             issue_valid;
   logic             issue_ready;
   logic [31:0]      operand1;
   logic [31:0]      operand2;
   logic [4:0]       execute_type;
   logic [TAG_W-1:0] issue_dest_tag;

   int checks = 0;
   int errors = 0;

   mul_div_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .disp_valid        (disp_valid),
      .disp_ready        (disp_ready),
      .disp_execute_type (disp_execute_type),
      .disp_dest_tag     (disp_dest_tag),
      .disp_src1_tag     (disp_src1_tag),
      .disp_src2_tag     (disp_src2_tag),
      .disp_src1_rdy     (disp_src1_rdy),
      .disp_src2_rdy     (disp_src2_rdy),
      .disp_src1_val     (disp_src1_val),
      .disp_src2_val     (disp_src2_val),
      .cdb_valid         (cdb_valid),
      .cdb_tag           (cdb_tag),
      .cdb_data          (cdb_data),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .operand1          (operand1),
      .operand2          (operand2),
      .execute_type      (execute_type),
      .issue_dest_tag    (issue_dest_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush             = 1'b0;
      disp_valid        = 1'b0;
      disp_execute_type = '0;
      disp_dest_tag     = '0;
      disp_src1_tag     = '0;
      disp_src2_tag     = '0;
      disp_src1_rdy     = 1'b0;
      disp_src2_rdy     = 1'b0;
      disp_src1_val     = '0;
      disp_src2_val     = '0;
      cdb_valid         = 1'b0;
      cdb_tag           = '0;
      cdb_data          = '0;
      issue_ready       = 1'b0;
   endtask

   task automatic set_disp(input logic [4:0] t, input logic [TAG_W-1:0] dest,
                           input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
      disp_valid        = 1'b1;
      disp_execute_type = t;
      disp_dest_tag     = dest;
      disp_src1_rdy     = r1;
      disp_src1_tag     = t1;
      disp_src1_val     = v1;
      disp_src2_rdy     = r2;
      disp_src2_tag     = t2;
      disp_src2_val     = v2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #2;
      checks++;
      if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
      checks++;
      if (operand1 !== 32'd0 || operand2 !== 32'd0 || execute_type !== 5'd0 || issue_dest_tag !== '0) begin
         errors++;
         $display("FAIL reset_outputs got op1=%0d op2=%0d type=%0d dest=%0d want all 0",
                  operand1, operand2, execute_type, issue_dest_tag);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_issue();
      set_disp(5'd1, 6'd3, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd7);
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_no_issue_same_cycle got %b want 0", issue_valid); end
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd6 || operand2 !== 32'd7 ||
          issue_dest_tag !== 6'd3 || execute_type !== 5'd1) begin
         errors++;
         $display("FAIL basic_issue got v=%b op1=%0d op2=%0d dest=%0d type=%0d want v=1 op1=6 op2=7 dest=3 type=1",
                  issue_valid, operand1, operand2, issue_dest_tag, execute_type);
      end
      tick();
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd6 || issue_dest_tag !== 6'd3) begin
         errors++;
         $display("FAIL basic_hold got v=%b op1=%0d dest=%0d want v=1 op1=6 dest=3", issue_valid, operand1, issue_dest_tag);
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      checks++;
      if (issue_valid !== 1'b0 || operand1 !== 32'd0) begin
         errors++;
         $display("FAIL basic_after_issue got v=%b op1=%0d want v=0 op1=0", issue_valid, operand1);
      end
   endtask

   task automatic test_wakeup();
      set_disp(5'd2, 6'd5, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2);
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_wait got %b want 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd100;
      #1;
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_latency got %b want 0", issue_valid); end
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd100 || operand2 !== 32'd2 || issue_dest_tag !== 6'd5) begin
         errors++;
         $display("FAIL wakeup_issue got v=%b op1=%0d op2=%0d dest=%0d want v=1 op1=100 op2=2 dest=5",
                  issue_valid, operand1, operand2, issue_dest_tag);
      end
      issue_ready = 1'b1;
      tick();
      idle();
      // Both sources of one entry waiting on the same tag.
      set_disp(5'd3, 6'd7, 1'b0, 6'd12, 32'd0, 1'b0, 6'd12, 32'd0);
      tick();
      idle();
      cdb_valid = 1'b1; cdb_tag = 6'd11; cdb_data = 32'd44;
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_wrong_tag got %b want 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'd33;
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd33 || operand2 !== 32'd33 || issue_dest_tag !== 6'd7) begin
         errors++;
         $display("FAIL wakeup_both got v=%b op1=%0d op2=%0d dest=%0d want v=1 op1=33 op2=33 dest=7",
                  issue_valid, operand1, operand2, issue_dest_tag);
      end
      issue_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_full_and_back_to_back();
      logic [TAG_W-1:0] exp_tags [3];
      for (int i = 0; i < 4; i++) begin
         set_disp(5'd4, 6'(i + 1), 1'b1, 6'd0, 32'(10 + i), 1'b1, 6'd0, 32'(20 + i));
         tick();
      end
      idle();
      checks++;
      if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready got %b want 0", disp_ready); end
      set_disp(5'd4, 6'd9, 1'b1, 6'd0, 32'd99, 1'b1, 6'd0, 32'd99);
      tick();
      idle();
      checks++;
      if (disp_ready !== 1'b0 || issue_dest_tag !== 6'd1 || operand1 !== 32'd10) begin
         errors++;
         $display("FAIL full_first_sel got rdy=%b dest=%0d op1=%0d want rdy=0 dest=1 op1=10",
                  disp_ready, issue_dest_tag, operand1);
      end
      issue_ready = 1'b1;
      #1;
      checks++;
      if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_no_same_cycle_room got %b want 0", disp_ready); end
      tick();
      issue_ready = 1'b0;
      checks++;
      if (disp_ready !== 1'b1 || issue_dest_tag !== 6'd2 || operand2 !== 32'd21) begin
         errors++;
         $display("FAIL full_after_issue got rdy=%b dest=%0d op2=%0d want rdy=1 dest=2 op2=21",
                  disp_ready, issue_dest_tag, operand2);
      end
      // Simultaneous dispatch into slot 0 and issue of slot 1.
      set_disp(5'd6, 6'd8, 1'b1, 6'd0, 32'd80, 1'b1, 6'd0, 32'd81);
      issue_ready = 1'b1;
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || issue_dest_tag !== 6'd8 || operand1 !== 32'd80 || execute_type !== 5'd6 || disp_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_sel got v=%b dest=%0d op1=%0d type=%0d rdy=%b want v=1 dest=8 op1=80 type=6 rdy=1",
                  issue_valid, issue_dest_tag, operand1, execute_type, disp_ready);
      end
      exp_tags[0] = 6'd8; exp_tags[1] = 6'd3; exp_tags[2] = 6'd4;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (issue_valid !== 1'b1 || issue_dest_tag !== exp_tags[i]) begin
            errors++;
            $display("FAIL drain_%0d got v=%b dest=%0d want v=1 dest=%0d", i, issue_valid, issue_dest_tag, exp_tags[i]);
         end
         issue_ready = 1'b1;
         tick();
         issue_ready = 1'b0;
      end
      checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_empty got v=%b rdy=%b want v=0 rdy=1", issue_valid, disp_ready);
      end
   endtask

   task automatic test_flush();
      set_disp(5'd1, 6'd20, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
      tick();
      set_disp(5'd1, 6'd21, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd2);
      tick();
      set_disp(5'd1, 6'd22, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
      flush = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 6'd30; cdb_data = 32'd5;
      #1;
      checks++;
      if (issue_valid !== 1'b1 || issue_dest_tag !== 6'd20) begin
         errors++;
         $display("FAIL flush_cycle_outputs got v=%b dest=%0d want v=1 dest=20", issue_valid, issue_dest_tag);
      end
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1 || operand1 !== 32'd0) begin
         errors++;
         $display("FAIL flush_after got v=%b rdy=%b op1=%0d want v=0 rdy=1 op1=0", issue_valid, disp_ready, operand1);
      end
      tick();
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got %b want 0", issue_valid); end
   endtask

   task automatic test_bypass();
      set_disp(5'd2, 6'd40, 1'b0, 6'd4, 32'd0, 1'b1, 6'd0, 32'd1);
      cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'd55;
      tick();
      idle();
`ifdef MUL_DIV_RS_BYPASS_EN
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd55 || issue_dest_tag !== 6'd40) begin
         errors++;
         $display("FAIL bypass_issue got v=%b op1=%0d dest=%0d want v=1 op1=55 dest=40", issue_valid, operand1, issue_dest_tag);
      end
`else
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL nobypass_missed got %b want 0", issue_valid); end
      tick();
      checks++;
      if (issue_valid !== 1'b0) begin errors++; $display("FAIL nobypass_still_wait got %b want 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'd56;
      tick();
      idle();
      checks++;
      if (issue_valid !== 1'b1 || operand1 !== 32'd56 || issue_dest_tag !== 6'd40) begin
         errors++;
         $display("FAIL nobypass_rebroadcast got v=%b op1=%0d dest=%0d want v=1 op1=56 dest=40", issue_valid, operand1, issue_dest_tag);
      end
`endif
      issue_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         set_disp(5'd5, 6'(50 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i));
         tick();
      end
      idle();
      checks++;
      if (issue_valid !== 1'b1 || issue_dest_tag !== 6'd50) begin
         errors++;
         $display("FAIL async_pre got v=%b dest=%0d want v=1 dest=50", issue_valid, issue_dest_tag);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1 || operand1 !== 32'd0 || issue_dest_tag !== '0) begin
         errors++;
         $display("FAIL async_reset got v=%b rdy=%b op1=%0d dest=%0d want v=0 rdy=1 op1=0 dest=0",
                  issue_valid, disp_ready, operand1, issue_dest_tag);
      end
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_after got v=%b rdy=%b want v=0 rdy=1", issue_valid, disp_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_wakeup();
      test_full_and_back_to_back();
      test_flush();
      test_bypass();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mul_div_rs.md
MUL_DIV_RS -- requirements
Module: mul_div_rs

Interface
REQ-001 SHALL have parameters, one per line: DEPTH, 4, number of station entries; TAG_W, 6, physical register tag width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first. One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all entries (mispredict)
- disp_valid  input  1  dispatch request
- disp_ready  output  1  free entry available
- disp_execute_type  input  5  Mul_Div operation code
- disp_dest_tag  input  TAG_W  destination tag
- disp_src1_tag / disp_src2_tag  input  TAG_W  source tags
- disp_src1_rdy / disp_src2_rdy  input  1  source value already valid
- disp_src1_val / disp_src2_val  input  32  source value when ready
- cdb_valid  input  1  common data bus broadcast
- cdb_tag  input  TAG_W  broadcast tag
- cdb_data  input  32  broadcast value
- issue_valid  output  1  operands ready for Mul_Div
- issue_ready  input  1  Mul_Div accepts this cycle
- operand1 / operand2  output  32  Mul_Div operands
- execute_type  output  5  Mul_Div operation code
- issue_dest_tag  output  TAG_W  tag for the result writeback

Function
REQ-003 Each entry SHALL hold: valid, execute_type, dest_tag, and, per source, tag, rdy and val.
REQ-004 disp_ready SHALL be 1 iff at least one entry is invalid. It is computed from registered state only; an issue in the same cycle does not make room.
REQ-005 On disp_valid&&disp_ready, the lowest-index invalid entry SHALL be written at the clock edge.
REQ-006 An entry SHALL be issue-eligible when valid&&src1_rdy&&src2_rdy. issue_valid is 1 iff any entry is eligible.
REQ-007 The selected entry SHALL be the lowest-index eligible entry. operand1/operand2/execute_type/issue_dest_tag come from it combinationally. All four outputs SHALL be 0 when issue_valid=0.
REQ-008 On issue_valid&&issue_ready, the selected entry SHALL be invalidated at the edge. The outputs SHALL hold stable while issue_valid&&!issue_ready.
REQ-009 On cdb_valid, every valid entry whose non-ready source tag equals cdb_tag SHALL capture cdb_data and set rdy at the edge. Both sources of one entry may wake in the same cycle.
REQ-010 A woken entry SHALL become eligible no earlier than the cycle after the CDB broadcast (1-cycle wakeup latency).
REQ-011 The minimum dispatch-to-issue latency SHALL be 1 cycle (both sources ready at dispatch).
REQ-012 Simultaneous dispatch and issue SHALL both take effect. The freed entry may be reused only in a later cycle.
REQ-013 flush SHALL invalidate all entries at the edge and override a same-cycle dispatch and wakeup. An issue handshake in the flush cycle still completes on the outputs.
REQ-014 Only the lowest-index-invalid and lowest-index-eligible scans are used; no age ordering is provided.

Reset
REQ-015 While rst_n=0, all entry valid and rdy bits SHALL be 0, with disp_ready=1, issue_valid=0, and operand1=operand2=0, execute_type=0, issue_dest_tag=0.
REQ-016 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk.

Configuration
REQ-017 Macro MUL_DIV_RS_BYPASS_EN controls dispatch-time CDB bypass.
- Defined: a dispatched source with rdy=0 whose tag equals cdb_tag while cdb_valid is written as ready with cdb_data.
- Undefined: such a source is written not-ready and waits for a later broadcast; a value broadcast in the dispatch cycle is missed.

Verification
REQ-018 Dispatch type=5'd1, src1 ready 32'd6, src2 ready 32'd7, tag 3 -> next cycle issue_valid=1, operand1=6, operand2=7, issue_dest_tag=3; with issue_ready=1, issue_valid=0 the cycle after.
REQ-019 Dispatch src1 tag 9 not ready, src2 ready 32'd2 -> issue_valid=0; cdb_valid with tag 9, data 32'd100 -> issue_valid=1 one cycle later with operand1=100.
REQ-020 Dispatch 4 ready ops with issue_ready=0 -> disp_ready=0 after the fourth; a fifth disp_valid is not accepted; one issue handshake -> disp_ready=1 next cycle, entry 0 issued first.
REQ-021 Fill 2 entries, assert flush with a same-cycle dispatch -> all entries invalid, issue_valid=0, disp_ready=1 next cycle.
REQ-022 With MUL_DIV_RS_BYPASS_EN defined, dispatch src1 tag 4 not ready while cdb tag 4, data 32'd55 -> issues next cycle with operand1=55. Without the macro -> issue_valid stays 0 until a new broadcast.
REQ-023 Assert rst_n=0 asynchronously with 3 valid entries -> issue_valid=0 and disp_ready=1 before the next clk edge.
